// File: rtl/adder_ahead_serial_sub.sv
// adder_ahead_serial_sub
//   Nibble-serial subtractor: diff = a - b - bin (mod 2^WIDTH), four bits per
//   clock through one 4-bit add stage (a + ~b + ~borrow) with a registered carry.
//
// Ports
//   clk_i, rst_i                   clock, synchronous active-high reset
//   in_valid_i / in_ready_o        operand handshake (accepted only in IDLE)
//   a_i, b_i, bin_i                minuend, subtrahend, borrow in
//   out_valid_o / out_ready_i      result handshake (presented in DONE)
//   diff_o, bout_o, ovf_o, zero_o  result, borrow out, signed overflow, zero flag
//
// state | meaning
// IDLE  | waiting for operands, in_ready_o high
// RUN   | one nibble per clock, low nibble first
// DONE  | result valid, held until the consumer takes it
module adder_ahead_serial_sub #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int MSB = WIDTH - 1;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("adder_ahead_serial_sub: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_inv_q, b_inv_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [CW+1:0]    nib_idx;
  logic [4:0]       nib_sum;
  logic             last_nib;

  assign nib_idx  = {cnt_q, 2'b00};
  assign nib_sum  = {1'b0, a_q[nib_idx +: 4]} + {1'b0, b_inv_q[nib_idx +: 4]} + {4'b0000, carry_q};
  assign last_nib = (cnt_q == CW'(NIB - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_inv_d = b_inv_q;
    carry_d = carry_q;
    res_d   = res_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          a_d     = a_i;
          b_inv_d = ~b_i;
          carry_d = ~bin_i;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[nib_idx +: 4] = nib_sum[3:0];
        carry_d = nib_sum[4];
        cnt_d   = cnt_q + 1'b1;
        if (last_nib) begin
          // Outputs only change here so the previous result stays visible during RUN.
          state_d = DONE;
          cnt_d   = '0;
          diff_d  = res_d;
          bout_d  = ~nib_sum[4];
          // b is stored inverted: a[MSB] != b[MSB] is a_q[MSB] == b_inv_q[MSB].
          ovf_d   = (a_q[MSB] == b_inv_q[MSB]) & (res_d[MSB] != a_q[MSB]);
          zero_d  = (res_d == '0);
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_inv_q <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_inv_q <= b_inv_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE) & ~rst_i;
  assign out_valid_o = (state_q == DONE);
  assign diff_o      = diff_q;
  assign bout_o      = bout_q;
  assign ovf_o       = ovf_q;
  assign zero_o      = zero_q;

endmodule

// File: doc/adder_ahead_serial_sub.md
Name: adder_ahead_serial_sub

Overview:
- Multi-cycle, nibble-serial subtractor; the subtract-direction counterpart of the team's 4-bit lookahead adder slices.
- Computes diff = a − b − bin over a WIDTH-bit operand, 4 bits per clock.
- Uses one 4-bit lookahead add stage and a registered carry. Each nibble is a + ~b with carry-in = ~borrow.
- Valid/ready on both sides. Sits between operand registers and a consumer that tolerates multi-cycle latency.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and ≥ 4; other values are illegal (elaboration error).
- NIB, WIDTH/4, derived number of nibble steps. Not user-overridable.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- in_valid_i  in  1  operands valid
- in_ready_o  out  1  block can accept operands
- a_i  in  WIDTH  minuend
- b_i  in  WIDTH  subtrahend
- bin_i  in  1  borrow in
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- diff_o  out  WIDTH  a − b − bin, mod 2^WIDTH
- bout_o  out  1  borrow out; 1 when unsigned a < b + bin
- ovf_o  out  1  signed two's-complement overflow
- zero_o  out  1  diff_o == 0

Behaviour:
- One clock; synchronous active-high reset.
- States: IDLE, RUN, DONE.
- Reset:
  - state = IDLE; nibble counter = 0; operand/result/carry registers = 0.
  - out_valid_o = 0, diff_o = 0, bout_o = 0, ovf_o = 0, zero_o = 1.
  - in_ready_o = 0 while rst_i is high.
- in_ready_o = (state == IDLE) & ~rst_i. Combinational from state; no dependence on in_valid_i.
- IDLE → RUN on in_valid_i & in_ready_o at an edge. On that edge:
  - a_i, b_i are captured; the block inverts and registers b.
  - Carry register = ~bin_i; counter = 0.
  - Later input changes are ignored.
- RUN, each edge:
  - Nibble k = counter: {c4, s} = a[4k+3:4k] + ~b[4k+3:4k] + carry.
  - Write s into result[4k+3:4k]; carry ← c4; counter increments.
  - On the edge where k = NIB−1: state → DONE.
  - Then: bout = ~c4; ovf = (a[MSB] ≠ b[MSB]) & (result[MSB] ≠ a[MSB]); zero = (full result == 0).
- Latency: acceptance at edge T gives out_valid_o = 1 after edge T+NIB. WIDTH=16 gives 4 cycles.
- DONE:
  - out_valid_o = 1. diff_o, bout_o, ovf_o and zero_o are stable and held.
  - Transition DONE → IDLE on out_valid_o & out_ready_i at an edge; out_valid_o drops after that edge.
  - Backpressure (out_ready_i = 0) holds DONE and all outputs indefinitely.
- Throughput: one operation per NIB+2 cycles minimum. There is no overlap; the IDLE bubble is intentional.
- Outputs keep the last result while in IDLE/RUN; only out_valid_o qualifies them.
- out_ready_i is ignored outside DONE; in_valid_i is ignored outside IDLE.
- Reset mid-RUN or mid-DONE: abort; next cycle is IDLE with all reset values. The partial result is discarded and never presented.
- Wrap-around: diff is mod 2^WIDTH; underflow is signalled only by bout_o.
- Counter width: $clog2(NIB) with a minimum of 1 bit.
- WIDTH=4: a single RUN cycle.

Test Plan:
- WIDTH=16; a=0x1234, b=0x0034, bin=0, out_ready=1 → out_valid_o 4 cycles after accept; diff=0x1200, bout=0, ovf=0, zero=0.
- a=0x0000, b=0x0001, bin=0 → diff=0xFFFF, bout=1, ovf=0.
- a=0x8000, b=0x0001, bin=0 → diff=0x7FFF, bout=0, ovf=1. Also a=0x7FFF, b=0xFFFF → diff=0x8000, bout=1, ovf=1.
- Borrow-in: a=0x0005, b=0x0005, bin=1 → diff=0xFFFF, bout=1, zero=0. Same with bin=0 → diff=0x0000, zero=1, bout=0.
- Backpressure: out_ready=0 for 10 cycles → out_valid/diff held and in_ready_o=0 throughout. Raise out_ready → out_valid drops next edge and in_ready_o returns to 1. Changing a_i/b_i during RUN does not alter the result.
- Reset after 2 RUN cycles → next cycle IDLE, in_ready_o=1, out_valid_o=0, diff_o=0, zero_o=1. The following op a=0xFFFF, b=0x0000 gives diff=0xFFFF, bout=0.
